// File: rtl/processor_ctrl.sv
// Multi-cycle control FSM for the processor datapath (fetch/decode/execute/memory/writeback).
// Define PROC_CTRL_PERF_EN to add the cycle_cnt / instr_cnt performance counters.
module processor_ctrl #(
  parameter int A           = 32,
  parameter int B           = 6,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [B-1:0] opcode,
  input  logic         zero,
  input  logic         mem_ready,
  output logic [2:0]   state,
  output logic         pc_en,
  output logic         pc_load,
  output logic         ir_load,
  output logic         mem_rd,
  output logic         mem_wr,
  output logic [3:0]   alu_op,
  output logic         reg_we,
  output logic         mem_to_reg,
  output logic         busy,
  output logic         illegal_op
`ifdef PROC_CTRL_PERF_EN
  ,
  output logic [A-1:0] cycle_cnt,
  output logic [A-1:0] instr_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6,
    ERROR  = 3'd7
  } state_t;

  localparam logic [B-1:0] OP_NOP    = B'('h00);
  localparam logic [B-1:0] OP_LOAD   = B'('h10);
  localparam logic [B-1:0] OP_STORE  = B'('h11);
  localparam logic [B-1:0] OP_BRANCH = B'('h20);
  localparam logic [B-1:0] OP_HALT   = B'('h3F);
  localparam logic [7:0]   WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t       state_q, state_d;
  logic [B-1:0] op_q;
  logic [7:0]   wait_cnt;
  logic         timeout;

  function automatic logic is_alu(input logic [B-1:0] op);
    return (op >= B'('h01)) && (op <= B'('h0F));
  endfunction

  function automatic logic is_legal(input logic [B-1:0] op);
    return (op == OP_NOP) || is_alu(op) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_BRANCH) || (op == OP_HALT);
  endfunction

  // A wait expires on its MEM_TIMEOUT-th cycle without mem_ready; mem_ready in that cycle still wins.
  assign timeout = (wait_cnt == WAIT_LAST) && !mem_ready;
  assign state   = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 8'd0;
    end else if (state_d != state_q) begin
      wait_cnt <= 8'd0;
    end else if (((state_q == FETCH) || (state_q == MEM)) && !mem_ready) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= '0;
      illegal_op <= 1'b0;
    end else if (state_q == DECODE) begin
      op_q <= opcode;
      if (!is_legal(opcode)) begin
        illegal_op <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    pc_load    = 1'b0;
    ir_load    = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    alu_op     = 4'h0;
    reg_we     = 1'b0;
    mem_to_reg = 1'b0;
    busy       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        busy   = 1'b1;
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          pc_en   = 1'b1;
          state_d = DECODE;
        end else if (timeout) begin
          state_d = ERROR;
        end
      end
      DECODE: begin
        busy = 1'b1;
        if (is_alu(opcode) || (opcode == OP_LOAD) || (opcode == OP_STORE) ||
            (opcode == OP_BRANCH)) begin
          state_d = EXEC;
        end else if (opcode == OP_HALT) begin
          state_d = HALT;
        end else begin
          state_d = FETCH;
        end
      end
      EXEC: begin
        busy = 1'b1;
        if (is_alu(op_q)) begin
          alu_op  = op_q[3:0];
          state_d = WB;
        end else if ((op_q == OP_LOAD) || (op_q == OP_STORE)) begin
          state_d = MEM;
        end else begin
          pc_load = zero;
          state_d = FETCH;
        end
      end
      MEM: begin
        busy   = 1'b1;
        mem_rd = (op_q == OP_LOAD);
        mem_wr = (op_q != OP_LOAD);
        if (mem_ready) begin
          state_d = (op_q == OP_LOAD) ? WB : FETCH;
        end else if (timeout) begin
          state_d = ERROR;
        end
      end
      WB: begin
        busy       = 1'b1;
        reg_we     = 1'b1;
        mem_to_reg = (op_q == OP_LOAD);
        state_d    = FETCH;
      end
      HALT: begin
        if (start) state_d = FETCH;
      end
      default: begin
        state_d = ERROR;
      end
    endcase
  end

`ifdef PROC_CTRL_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (busy) cycle_cnt <= cycle_cnt + 1'b1;
      if (state_q == DECODE) instr_cnt <= instr_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_processor_ctrl.sv
// Directed testbench for processor_ctrl with hand-computed expected values.
module tb_processor_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic [2:0] state;
  logic       pc_en, pc_load, ir_load, mem_rd, mem_wr;
  logic [3:0] alu_op;
  logic       reg_we, mem_to_reg, busy, illegal_op;
`ifdef PROC_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  processor_ctrl #(.A(32), .B(6), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .state(state), .pc_en(pc_en), .pc_load(pc_load),
    .ir_load(ir_load), .mem_rd(mem_rd), .mem_wr(mem_wr), .alu_op(alu_op),
    .reg_we(reg_we), .mem_to_reg(mem_to_reg), .busy(busy), .illegal_op(illegal_op)
`ifdef PROC_CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, checks follow after #1.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b0;
    tick(); tick();
    #1;
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_illegal", illegal_op, 0);
    reset = 1'b0;

    // ALU 0x05: states 1,2,3,5,1
    start = 1'b1; mem_ready = 1'b1; opcode = 6'h05;
    #1 chk("idle_state", state, 0);
    tick(); start = 1'b0; #1;
    chk("alu_fetch", state, 1);
    chk("alu_fetch_rd", mem_rd, 1);
    chk("alu_fetch_ir", ir_load, 1);
    chk("alu_fetch_pcen", pc_en, 1);
    chk("alu_fetch_busy", busy, 1);
    tick(); #1;
    chk("alu_decode", state, 2);
    chk("alu_decode_rd", mem_rd, 0);
    tick(); opcode = 6'h3F; #1;
    chk("alu_exec", state, 3);
    chk("alu_exec_op", alu_op, 4'h5);
    tick(); #1;
    chk("alu_wb", state, 5);
    chk("alu_wb_we", reg_we, 1);
    chk("alu_wb_m2r", mem_to_reg, 0);
    tick(); #1;
    chk("alu_back_fetch", state, 1);
    chk("alu_we_1cyc", reg_we, 0);

    // LOAD 0x10 with mem_ready delayed in MEM
    opcode = 6'h10;
    tick(); #1 chk("ld_decode", state, 2);
    tick(); mem_ready = 1'b0; #1;
    chk("ld_exec", state, 3);
    chk("ld_exec_op", alu_op, 4'h0);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("ld_mem_state", state, 4);
      chk("ld_mem_rd", mem_rd, 1);
      chk("ld_mem_wr", mem_wr, 0);
    end
    mem_ready = 1'b1; #1;
    chk("ld_mem_irload", ir_load, 0);
    tick(); #1;
    chk("ld_wb", state, 5);
    chk("ld_wb_m2r", mem_to_reg, 1);
    chk("ld_wb_we", reg_we, 1);
    tick(); #1 chk("ld_back_fetch", state, 1);

    // BRANCH 0x20: pc_load follows zero in EXEC
    opcode = 6'h20;
    tick(); tick(); zero = 1'b1; #1;
    chk("br_exec", state, 3);
    chk("br_z1_load", pc_load, 1);
    zero = 1'b0; #1;
    chk("br_z0_load", pc_load, 0);
    tick(); #1;
    chk("br_back_fetch", state, 1);
    chk("br_fetch_load", pc_load, 0);

    // Illegal 0x2A: sticky flag, treated as NOP
    opcode = 6'h2A;
    tick(); #1 chk("ill_decode_flag", illegal_op, 0);
    tick(); #1;
    chk("ill_next_fetch", state, 1);
    chk("ill_flag_set", illegal_op, 1);
    opcode = 6'h00;
    tick(); tick(); #1;
    chk("nop_fetch", state, 1);
    chk("ill_sticky", illegal_op, 1);

    // HALT 0x3F, start resumes
    opcode = 6'h3F;
    tick(); tick(); #1;
    chk("halt_state", state, 6);
    chk("halt_busy", busy, 0);
    tick(); #1 chk("halt_stay", state, 6);
    start = 1'b1;
    tick(); start = 1'b0; #1 chk("halt_resume", state, 1);

    // Timeout boundary: mem_ready arriving on the 15th wait cycle still wins
    opcode = 6'h00; mem_ready = 1'b0; #1;
    chk("wait_pcen", pc_en, 0);
    for (int i = 0; i < 14; i++) tick();
    #1 chk("wait15_fetch", state, 1);
    mem_ready = 1'b1;
    tick(); #1 chk("ready_wins", state, 2);
    tick(); #1 chk("ready_wins_fetch", state, 1);

    // Timeout: 15 FETCH cycles without mem_ready -> ERROR
    mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    #1 chk("to_still_fetch", state, 1);
    tick(); #1;
    chk("to_error", state, 7);
    chk("to_error_rd", mem_rd, 0);
    mem_ready = 1'b1; start = 1'b1;
    tick(); #1 chk("error_stuck", state, 7);
    start = 1'b0;
    reset = 1'b1; #1;
    chk("error_reset", state, 0);
    chk("reset_clr_ill", illegal_op, 0);
    tick(); reset = 1'b0;

    // STORE 0x11 interrupted by reset in MEM
    opcode = 6'h11; start = 1'b1; mem_ready = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); mem_ready = 1'b0;
    tick(); #1;
    chk("st_mem", state, 4);
    chk("st_mem_wr", mem_wr, 1);
    chk("st_mem_rd", mem_rd, 0);
    #1 reset = 1'b1; #1;
    chk("st_rst_wr", mem_wr, 0);
    chk("st_rst_state", state, 0);
    chk("st_rst_busy", busy, 0);
`ifdef PROC_CTRL_PERF_EN
    chk("st_rst_cyc", cycle_cnt, 0);
    chk("st_rst_ins", instr_cnt, 0);
`endif
    tick(); reset = 1'b0; #1;
    chk("st_idle_after", state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
